// File: rtl/dig_ct_pkg.sv
// Shared widths, FSM states and requester ID type for the DigCt scheduler.
package dig_ct_pkg;

  localparam int VEC_W = 5;
  localparam int RES_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_e;

  typedef logic req_id_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick; combinational winner, registered priority pointer.
// The pointer only moves when the caller consumes the pick via take.
module rr_arb2
  import dig_ct_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       take,
  output logic       req_any,
  output req_id_t    win
);

  req_id_t prio_q;
  req_id_t prio_d;

  always_comb begin
    req_any = |req;
    win     = prio_q;
    // A lone requester wins outright; the pointer only breaks ties.
    if (req == 2'b01) begin
      win = 1'b0;
    end else if (req == 2'b10) begin
      win = 1'b1;
    end
    prio_d = prio_q;
    if (take && req_any) begin
      prio_d = ~win;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/dig_ct_arb.sv
// Shares one DigCt stage between two clients: grant, drive CT_IN, wait SETTLE
// clocks, capture CT_OUT and hold the result until RES_RDY accepts it.
module dig_ct_arb
  import dig_ct_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ0,
  input  logic             REQ1,
  input  logic [VEC_W-1:0] VEC0,
  input  logic [VEC_W-1:0] VEC1,
  output logic             GNT0,
  output logic             GNT1,
  output logic [VEC_W-1:0] CT_IN,
  input  logic [RES_W-1:0] CT_OUT,
  output logic [RES_W-1:0] RES,
  output logic             RES_ID,
  output logic             RES_VLD,
  input  logic             RES_RDY,
  output logic             BUSY
);

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

  state_e           state_q,   state_d;
  logic [3:0]       cnt_q,     cnt_d;
  logic             gnt0_q,    gnt0_d;
  logic             gnt1_q,    gnt1_d;
  logic [VEC_W-1:0] ct_in_q,   ct_in_d;
  req_id_t          owner_q,   owner_d;
  logic [RES_W-1:0] res_q,     res_d;
  req_id_t          res_id_q,  res_id_d;
  logic             res_vld_q, res_vld_d;

  logic    arb_any;
  logic    arb_take;
  req_id_t arb_win;

  rr_arb2 u_rr_arb2 (
    .clk     (CLK),
    .rst     (RST),
    .req     ({REQ1, REQ0}),
    .take    (arb_take),
    .req_any (arb_any),
    .win     (arb_win)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    ct_in_d   = ct_in_q;
    owner_d   = owner_q;
    res_d     = res_q;
    res_id_d  = res_id_q;
    res_vld_d = res_vld_q;
    arb_take  = 1'b0;

    case (state_q)
      IDLE: begin
        arb_take = arb_any;
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = CNT_LOAD;
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          res_d     = CT_OUT;
          res_vld_d = 1'b1;
          res_id_d  = owner_q;
          state_d   = HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HOLD: begin
        // Requests are only looked at once the held result has been taken.
        if (res_vld_q && RES_RDY) begin
          res_vld_d = 1'b0;
          arb_take  = arb_any;
          if (!arb_any) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (arb_take) begin
      state_d = ISSUE;
      owner_d = arb_win;
      gnt0_d  = ~arb_win;
      gnt1_d  = arb_win;
      ct_in_d = arb_win ? VEC1 : VEC0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      ct_in_q   <= '0;
      owner_q   <= 1'b0;
      res_q     <= '0;
      res_id_q  <= 1'b0;
      res_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      ct_in_q   <= ct_in_d;
      owner_q   <= owner_d;
      res_q     <= res_d;
      res_id_q  <= res_id_d;
      res_vld_q <= res_vld_d;
    end
  end

  assign GNT0    = gnt0_q;
  assign GNT1    = gnt1_q;
  assign CT_IN   = ct_in_q;
  assign RES     = res_q;
  assign RES_ID  = res_id_q;
  assign RES_VLD = res_vld_q;
  assign BUSY    = (state_q != IDLE);

endmodule

// File: tb/tb_dig_ct_arb.sv
// Bench for dig_ct_arb: two instances (SETTLE=1 and SETTLE=3), each driving a
// registered DigCt stand-in, with a result scoreboard per instance.
module tb_dig_ct_arb;
  import dig_ct_pkg::*;

  typedef struct packed {
    logic       id;
    logic [2:0] res;
  } exp_t;

  int total = 0;
  int bad   = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A, SETTLE = 1
  logic       req0 = 1'b0, req1 = 1'b0, res_rdy = 1'b1;
  logic [4:0] vec0 = '0, vec1 = '0;
  logic       gnt0, gnt1, res_id, res_vld, busy;
  logic [4:0] ct_in;
  logic [2:0] ct_out = '0;
  logic [2:0] res;

  // Instance B, SETTLE = 3
  logic       b_req0 = 1'b0, b_req1 = 1'b0, b_res_rdy = 1'b1;
  logic [4:0] b_vec0 = '0, b_vec1 = '0;
  logic       b_gnt0, b_gnt1, b_res_id, b_res_vld, b_busy;
  logic [4:0] b_ct_in;
  logic [2:0] b_ct_out = '0;
  logic [2:0] b_res;

  exp_t sbq[$];
  exp_t b_sbq[$];

  dig_ct_arb #(.SETTLE(1)) u_a (
    .CLK(clk), .RST(rst), .REQ0(req0), .REQ1(req1), .VEC0(vec0), .VEC1(vec1),
    .GNT0(gnt0), .GNT1(gnt1), .CT_IN(ct_in), .CT_OUT(ct_out), .RES(res),
    .RES_ID(res_id), .RES_VLD(res_vld), .RES_RDY(res_rdy), .BUSY(busy)
  );

  dig_ct_arb #(.SETTLE(3)) u_b (
    .CLK(clk), .RST(rst), .REQ0(b_req0), .REQ1(b_req1), .VEC0(b_vec0), .VEC1(b_vec1),
    .GNT0(b_gnt0), .GNT1(b_gnt1), .CT_IN(b_ct_in), .CT_OUT(b_ct_out), .RES(b_res),
    .RES_ID(b_res_id), .RES_VLD(b_res_vld), .RES_RDY(b_res_rdy), .BUSY(b_busy)
  );

  // Stand-in gate network for DigCt, output registered on the clock.
  function automatic logic [2:0] digct(input logic [4:0] v);
    logic [2:0] o;
    o[0] = v[3] | ~v[2];
    o[1] = ~v[1] & (v[2] ^ v[3]);
    o[2] = v[2] | v[4];
    return o;
  endfunction

  function automatic exp_t mk(input logic id, input logic [2:0] r);
    exp_t e;
    e.id  = id;
    e.res = r;
    return e;
  endfunction

  always @(posedge clk) begin
    ct_out   <= digct(ct_in);
    b_ct_out <= digct(b_ct_in);
  end

  // Inputs change at negedge+1; the monitors look at negedge+2.
  always @(negedge clk) begin : mon_a
    exp_t e;
    #2;
    if (!rst && res_vld && res_rdy) begin
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL sb_a: got id=%0d res=%b, required no result", res_id, res);
      end else begin
        e = sbq.pop_front();
        if ({res_id, res} !== e) begin
          bad++;
          $display("FAIL sb_a: got id=%0d res=%b, required id=%0d res=%b", res_id, res, e.id, e.res);
        end
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    #2;
    if (!rst && b_res_vld && b_res_rdy) begin
      total++;
      if (b_sbq.size() == 0) begin
        bad++;
        $display("FAIL sb_b: got id=%0d res=%b, required no result", b_res_id, b_res);
      end else begin
        e = b_sbq.pop_front();
        if ({b_res_id, b_res} !== e) begin
          bad++;
          $display("FAIL sb_b: got id=%0d res=%b, required id=%0d res=%b", b_res_id, b_res, e.id, e.res);
        end
      end
    end
  end

  task automatic wait_gnt_a(input logic id, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (id ? gnt1 : gnt0) ok = 1'b1;
    end
  endtask

  task automatic wait_idle_a(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 40);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_idle: busy=%b after %0d cycles, required 0", name, busy, n);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({gnt0, gnt1, res_id, res_vld, busy} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctrl: gnt0,gnt1,id,vld,busy=%b, required 00000", {gnt0, gnt1, res_id, res_vld, busy});
    end
    total++;
    if (ct_in !== 5'b0 || res !== 3'b0) begin
      bad++;
      $display("FAIL reset_data: ct_in=%b res=%b, required 00000 000", ct_in, res);
    end
    total++;
    if ({b_gnt0, b_gnt1, b_res_vld, b_busy} !== 4'b0) begin
      bad++;
      $display("FAIL reset_b: gnt0,gnt1,vld,busy=%b, required 0000", {b_gnt0, b_gnt1, b_res_vld, b_busy});
    end
    #1 rst = 1'b0;
  endtask

  task automatic test_single;
    bit ok;
    int lat;
    @(negedge clk);
    #1;
    vec0 = 5'b00100; req0 = 1'b1; res_rdy = 1'b1;
    sbq.push_back(mk(1'b0, 3'b110));
    wait_gnt_a(1'b0, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL single_gnt: no GNT0 within 40 cycles, required GNT0"); end
    total++;
    if (ct_in !== 5'b00100 || gnt1 !== 1'b0) begin
      bad++;
      $display("FAIL single_issue: ct_in=%b gnt1=%b, required 00100 0", ct_in, gnt1);
    end
    #1 req0 = 1'b0;
    @(negedge clk);
    lat = 1;
    total++;
    if (gnt0 !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL single_pulse: gnt0=%b busy=%b, required 0 1", gnt0, busy);
    end
    while (!res_vld && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    total++;
    if (lat != 2) begin bad++; $display("FAIL single_latency: %0d cycles GNT->RES_VLD, required 2", lat); end
    total++;
    if (res !== 3'b110 || res_id !== 1'b0) begin
      bad++;
      $display("FAIL single_res: res=%b id=%0d, required 110 0", res, res_id);
    end
    @(negedge clk);
    total++;
    if (res_vld !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL single_done: vld=%b busy=%b, required 0 0", res_vld, busy);
    end
  endtask

  task automatic test_simul;
    int gap;
    #1 rst = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
    vec0 = 5'b01110; vec1 = 5'b01000; req0 = 1'b1; req1 = 1'b1;
    sbq.push_back(mk(1'b0, 3'b101));
    sbq.push_back(mk(1'b1, 3'b011));
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (gnt0 || gnt1) break;
    end
    total++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      bad++;
      $display("FAIL simul_first: gnt0=%b gnt1=%b, required 1 0", gnt0, gnt1);
    end
    #1 req0 = 1'b0;
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (!gnt1 && gap < 40);
    total++;
    if (gap != 3) begin bad++; $display("FAIL simul_b2b: GNT1 %0d cycles after GNT0, required 3", gap); end
    #1 req1 = 1'b0;
    wait_idle_a("simul");
  endtask

  task automatic test_fairness;
    int  n;
    logic want1;
    #1;
    vec0 = 5'b10011; vec1 = 5'b00110; req0 = 1'b1; req1 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      sbq.push_back(mk(k[0], digct(k[0] ? vec1 : vec0)));
    end
    n = 0;
    for (int i = 0; i < 80 && n < 6; i++) begin
      @(negedge clk);
      if (gnt0 || gnt1) begin
        want1 = (n % 2 == 1);
        total++;
        if (gnt1 !== want1 || gnt0 !== ~want1) begin
          bad++;
          $display("FAIL fair_order: grant %0d gnt0=%b gnt1=%b, required gnt1=%b", n, gnt0, gnt1, want1);
        end
        n++;
        if (n == 6) begin
          #1; req0 = 1'b0; req1 = 1'b0;
        end
      end
    end
    total++;
    if (n != 6) begin bad++; $display("FAIL fair_count: %0d grants, required 6", n); end
    req0 = 1'b0; req1 = 1'b0;
    wait_idle_a("fair");
  endtask

  task automatic test_backpressure;
    bit   ok;
    int   n;
    int   stall_bad;
    logic [2:0] r;
    logic rid;
    #1;
    vec1 = 5'b11111; req1 = 1'b1; res_rdy = 1'b0;
    sbq.push_back(mk(1'b1, digct(5'b11111)));
    wait_gnt_a(1'b1, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL bp_gnt: no GNT1 within 40 cycles, required GNT1"); end
    #1;
    req1 = 1'b0; vec0 = 5'b00011; req0 = 1'b1;
    sbq.push_back(mk(1'b0, digct(5'b00011)));
    n = 0;
    while (!res_vld && n < 20) begin
      @(negedge clk);
      n++;
    end
    r = res; rid = res_id;
    total++;
    if (r !== digct(5'b11111) || rid !== 1'b1 || res_vld !== 1'b1) begin
      bad++;
      $display("FAIL bp_res: res=%b id=%0d vld=%b, required %b 1 1", r, rid, res_vld, digct(5'b11111));
    end
    stall_bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (res !== r || res_id !== rid || res_vld !== 1'b1 || gnt0 || gnt1) stall_bad++;
    end
    total++;
    if (stall_bad != 0) begin
      bad++;
      $display("FAIL bp_stall: %0d cycles changed or granted while stalled, required 0", stall_bad);
    end
    #1 res_rdy = 1'b1;
    @(negedge clk);
    total++;
    if (res_vld !== 1'b0 || gnt0 !== 1'b1) begin
      bad++;
      $display("FAIL bp_release: vld=%b gnt0=%b, required 0 1", res_vld, gnt0);
    end
    #1 req0 = 1'b0;
    wait_idle_a("bp");
  endtask

  task automatic test_settle3;
    bit ok;
    int lat;
    #1;
    b_vec1 = 5'b00100; b_req1 = 1'b1; b_res_rdy = 1'b1;
    b_sbq.push_back(mk(1'b1, 3'b110));
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (b_gnt1) ok = 1'b1;
    end
    total++;
    if (!ok || b_gnt0 !== 1'b0) begin
      bad++;
      $display("FAIL s3_gnt: gnt1 seen=%0d gnt0=%b, required 1 0", ok, b_gnt0);
    end
    #1 b_req1 = 1'b0;
    lat = 0;
    while (!b_res_vld && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    total++;
    if (lat != 4) begin bad++; $display("FAIL s3_latency: %0d cycles GNT->RES_VLD, required 4", lat); end
    total++;
    if (b_res !== 3'b110 || b_res_id !== 1'b1) begin
      bad++;
      $display("FAIL s3_res: res=%b id=%0d, required 110 1", b_res, b_res_id);
    end
    @(negedge clk);
    total++;
    if (b_busy !== 1'b0 || b_res_vld !== 1'b0) begin
      bad++;
      $display("FAIL s3_done: busy=%b vld=%b, required 0 0", b_busy, b_res_vld);
    end
  endtask

  task automatic test_reset_in_wait;
    bit ok;
    int seen;
    int n;
    #1;
    vec0 = 5'b00001; req0 = 1'b1;
    wait_gnt_a(1'b0, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL rw_gnt: no GNT0 within 40 cycles, required GNT0"); end
    #1 req0 = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL rw_busy: busy=%b in WAIT, required 1", busy); end
    #1 rst = 1'b1;
    #1;
    total++;
    if ({gnt0, gnt1, res_id, res_vld, busy} !== 5'b0 || ct_in !== 5'b0 || res !== 3'b0) begin
      bad++;
      $display("FAIL rw_async: ctrl=%b ct_in=%b res=%b, required all zero", {gnt0, gnt1, res_id, res_vld, busy}, ct_in, res);
    end
    @(negedge clk);
    #1 rst = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (res_vld || gnt0 || gnt1) seen++;
    end
    total++;
    if (seen != 0) begin bad++; $display("FAIL rw_lost: %0d cycles with vld/gnt after reset, required 0", seen); end
    #1;
    vec1 = 5'b01000; req1 = 1'b1;
    sbq.push_back(mk(1'b1, 3'b011));
    wait_gnt_a(1'b1, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL rw_fresh_gnt: no GNT1 within 40 cycles, required GNT1"); end
    #1 req1 = 1'b0;
    n = 0;
    while (!res_vld && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (res !== 3'b011 || res_id !== 1'b1) begin
      bad++;
      $display("FAIL rw_fresh_res: res=%b id=%0d, required 011 1", res, res_id);
    end
    wait_idle_a("rw");
  endtask

  initial begin
    test_reset();
    test_single();
    test_simul();
    test_fairness();
    test_backpressure();
    test_settle3();
    test_reset_in_wait();
    repeat (3) @(negedge clk);
    total++;
    if (sbq.size() != 0 || b_sbq.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover: a=%0d b=%0d results never seen, required 0 0", sbq.size(), b_sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dig_ct_arb.md
# dig_ct_arb

Two-requester round-robin scheduler that shares one DigCt gate-and-register stage between two independent clients. It accepts a 5-bit input vector from the granted requester and drives it onto the DigCt inputs. It waits out the DigCt register latency, captures the 3-bit result, and returns it with a requester ID over a valid/ready handshake. It sits between the client logic and the single DigCt instance; DigCt itself remains a separate, unmodified block.

## Interface
- SETTLE, default 1: number of clocks spent in WAIT for the DigCt output register; legal range 1..15.
- CLK  in  1  rising-edge clock shared with DigCt.
- RST  in  1  reset; asynchronous and active-high.
- REQ0, REQ1  in  1 each  request from client 0 / 1; held until the matching GNT is seen.
- VEC0, VEC1  in  5 each  operand vector; stable while the matching REQ is high. Bit 0 = IN1 … bit 4 = IN5.
- GNT0, GNT1  out  1 each  one-cycle grant pulse; the vector is accepted in that cycle.
- CT_IN  out  5  registered drive to DigCt IN1..IN5 (bit 0 = IN1).
- CT_OUT  in  3  from DigCt, {OUT3, OUT2, OUT1}.
- RES  out  3  captured result, {OUT3, OUT2, OUT1}.
- RES_ID  out  1  requester that owns RES.
- RES_VLD  out  1  result valid.
- RES_RDY  in  1  consumer ready.
- BUSY  out  1  high in every state except IDLE.

## Operation
- FSM states:
  - IDLE: REQ0/REQ1 are sampled only here.
    - Any request → ISSUE (winner chosen by round-robin).
    - No request → stay.
  - ISSUE: exactly 1 cycle.
    - CT_IN holds the winner's VEC.
    - GNTn = 1; the owner ID is latched.
    - Next state is WAIT; the counter loads SETTLE-1.
  - WAIT: lasts SETTLE cycles, decrementing a 4-bit counter.
    - CT_IN is held throughout.
    - On the count of 0: RES ← CT_OUT, RES_VLD ← 1, RES_ID ← owner, next state HOLD.
  - HOLD: RES, RES_ID and RES_VLD are held until RES_VLD && RES_RDY at a clock edge.
    - On that edge RES_VLD drops.
    - If any REQ is high → ISSUE directly (back-to-back); otherwise → IDLE.
- Round-robin rules:
  - The last-granted requester gets the lower priority for the next grant.
  - After reset, requester 0 has priority.
  - A lone request always wins regardless of the pointer.
- REQ is ignored outside IDLE/HOLD-exit. Requesters must deassert REQ by the edge following GNT, or the request is treated as a new one.
- Only one operation is in flight at a time; no queuing.

## Timing
- Reset (asynchronous, immediate):
  - State = IDLE.
  - GNT0 = GNT1 = 0, CT_IN = 5'b0, RES = 3'b0, RES_ID = 0, RES_VLD = 0, BUSY = 0.
  - Counter = 0; RR pointer favours requester 0.
- REQ seen in IDLE at edge E0 → GNT and CT_IN valid in the cycle after E0.
- DigCt registers CT_IN at edge E0+1.
- RES_VLD rises after edge E0+1+SETTLE. With SETTLE = 1, RES_VLD is high 2 cycles after GNT.
- Minimum period per operation is 2+SETTLE cycles when RES_RDY is held high and requests stay pending. This is HOLD→ISSUE back-to-back.
- RES_RDY low stalls indefinitely in HOLD; no new GNT is issued while stalled.
- Both REQ high in the same IDLE cycle: the pointer decides; the loser stays pending and is granted next.
- Reset mid-operation: the in-flight operation is lost and no GNT or RES_VLD is produced for it. Clients must re-request.

## Structure
- Package dig_ct_pkg holds:
  - VEC_W = 5 and RES_W = 3.
  - The state enum {IDLE, ISSUE, WAIT, HOLD}.
  - The requester ID type.
- Sub-module rr_arb2: combinational 2-way round-robin pick with a registered priority pointer, updated only on a grant. The FSM, counter and capture registers stay in dig_ct_arb.

## Test plan
- Single request: REQ0 with VEC0 = 5'b00100, SETTLE = 1, RES_RDY = 1 → GNT0 pulse, then RES = 3'b110, RES_ID = 0, RES_VLD high 2 cycles after GNT0.
- Simultaneous requests from reset: REQ0 with VEC0 = 5'b01110 and REQ1 with VEC1 = 5'b01000, both in the same cycle → GNT0 first, RES = 3'b101, ID 0. Then GNT1 back-to-back, RES = 3'b011, ID 1.
- Fairness: REQ0 and REQ1 held continuously → grants alternate 0,1,0,1 with no more than one consecutive grant per requester.
- Back-pressure: RES_RDY low for 5 cycles after RES_VLD rises → RES and RES_ID stable, no GNT issued. Completion is on the edge where RES_RDY rises.
- SETTLE = 3: REQ1 with VEC1 = 5'b00100 → RES_VLD rises 4 cycles after GNT1, RES = 3'b110.
- Reset in WAIT: RST pulsed mid-operation → all outputs are at their reset values immediately and no RES_VLD follows. A fresh REQ is then served normally.
